// File: rtl/reg_write_arbiter.sv
// reg_write_arbiter: round-robin write-back arbiter with per-channel FIFOs and per-register pending mask
// Ports:
//   clk_i         clock, all state updates on the rising edge
//   rst_i         synchronous active-high reset, overrides everything
//   flush_i       synchronous discard of all queued writes
//   in_valid_i    per-channel write request
//   in_ready_o    per-channel space available (FIFO not full, not flushing)
//   in_gf_i       per-channel file select, 0 general / 1 float
//   in_num_i      per-channel register index, channel c at [c*NUM_W +: NUM_W]
//   in_data_i     per-channel write data, channel c at [c*DATA_W +: DATA_W]
//   wr_valid_o    registered: a write is issued this cycle
//   wr_rnum_o     registered: full index {gf, num} of the issued write
//   wr_data_o     registered: data of the issued write
//   wr_enables_o  registered: one-hot of wr_rnum_o when wr_valid_o, else 0
//   pending_o     bit r set while at least one accepted write to r is not yet issued
module reg_write_arbiter #(
    parameter int NCH    = 2,
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32,
    parameter int NUM_W  = 4
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         flush_i,
    input  logic [NCH-1:0]               in_valid_i,
    output logic [NCH-1:0]               in_ready_o,
    input  logic [NCH-1:0]               in_gf_i,
    input  logic [NCH*NUM_W-1:0]         in_num_i,
    input  logic [NCH*DATA_W-1:0]        in_data_i,
    output logic                         wr_valid_o,
    output logic [NUM_W:0]               wr_rnum_o,
    output logic [DATA_W-1:0]            wr_data_o,
    output logic [2**(NUM_W+1)-1:0]      wr_enables_o,
    output logic [2**(NUM_W+1)-1:0]      pending_o
);
    localparam int RW   = NUM_W + 1;
    localparam int NREG = 2 ** RW;
    localparam int AW   = $clog2(DEPTH);
    localparam int CW   = $clog2(NCH * DEPTH + 1);
    localparam int PW   = NCH > 1 ? $clog2(NCH) : 1;

    typedef struct packed {
        logic [RW-1:0]     rnum;
        logic [DATA_W-1:0] data;
    } ent_t;

    ent_t            mem_q [NCH][DEPTH];
    logic [AW-1:0]   wp_q [NCH], wp_d [NCH], rp_q [NCH], rp_d [NCH];
    logic [AW:0]     fc_q [NCH], fc_d [NCH];
    logic [CW-1:0]   pc_q [NREG], pc_d [NREG];
    logic [PW-1:0]   rr_q, rr_d;
    ent_t            in_e [NCH];
    logic [NCH-1:0]  push, pop;
    ent_t            g_e;
    logic            g_v;
    logic            wr_valid_q, wr_valid_d;
    logic [RW-1:0]   wr_rnum_q, wr_rnum_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;
    logic [NREG-1:0] wr_en_q, wr_en_d;

    // Ready depends only on registered occupancy, so a full FIFO stays closed even in a pop cycle.
    // Writes to the hard-wired zero register complete the handshake but are never queued.
    always_comb begin
        for (int c = 0; c < NCH; c++) begin
            in_e[c].rnum  = {in_gf_i[c], in_num_i[c*NUM_W +: NUM_W]};
            in_e[c].data  = in_data_i[c*DATA_W +: DATA_W];
            in_ready_o[c] = ~flush_i & (fc_q[c] != (AW+1)'(DEPTH));
            push[c]       = in_valid_i[c] & in_ready_o[c] & (in_e[c].rnum != '0);
        end
    end

    // Round-robin search starting at rr_q; flush suppresses the grant.
    always_comb begin : arb
        int j;
        g_v  = 1'b0;
        g_e  = '0;
        pop  = '0;
        rr_d = rr_q;
        j    = 0;
        for (int i = 0; i < NCH; i++) begin
            j = int'(rr_q) + i;
            j = j >= NCH ? j - NCH : j;
            if (!g_v && !flush_i && fc_q[j] != '0) begin
                g_v    = 1'b1;
                g_e    = mem_q[j][rp_q[j]];
                pop[j] = 1'b1;
                rr_d   = PW'((j + 1) % NCH);
            end
        end
    end

    // Pending counters sum all same-cycle increments and the decrement for one register.
    always_comb begin
        for (int c = 0; c < NCH; c++) begin
            wp_d[c] = flush_i ? '0 : wp_q[c] + AW'(push[c]);
            rp_d[c] = flush_i ? '0 : rp_q[c] + AW'(pop[c]);
            fc_d[c] = flush_i ? '0 : fc_q[c] + (AW+1)'(push[c]) - (AW+1)'(pop[c]);
        end
        for (int r = 0; r < NREG; r++) pc_d[r] = flush_i ? '0 : pc_q[r];
        for (int c = 0; c < NCH; c++) if (push[c]) pc_d[in_e[c].rnum] = pc_d[in_e[c].rnum] + CW'(1);
        if (g_v) pc_d[g_e.rnum] = pc_d[g_e.rnum] - CW'(1);
        wr_valid_d = g_v;
        wr_rnum_d  = g_v ? g_e.rnum : wr_rnum_q;
        wr_data_d  = g_v ? g_e.data : wr_data_q;
        wr_en_d    = g_v ? NREG'(1) << g_e.rnum : '0;
        for (int r = 0; r < NREG; r++) pending_o[r] = pc_q[r] != '0;
    end

    always_ff @(posedge clk_i) begin
        for (int c = 0; c < NCH; c++) if (push[c]) mem_q[c][wp_q[c]] <= in_e[c];
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int c = 0; c < NCH; c++) begin
                wp_q[c] <= '0;
                rp_q[c] <= '0;
                fc_q[c] <= '0;
            end
            for (int r = 0; r < NREG; r++) pc_q[r] <= '0;
            rr_q       <= '0;
            wr_valid_q <= 1'b0;
            wr_rnum_q  <= '0;
            wr_data_q  <= '0;
            wr_en_q    <= '0;
        end else begin
            wp_q       <= wp_d;
            rp_q       <= rp_d;
            fc_q       <= fc_d;
            pc_q       <= pc_d;
            rr_q       <= rr_d;
            wr_valid_q <= wr_valid_d;
            wr_rnum_q  <= wr_rnum_d;
            wr_data_q  <= wr_data_d;
            wr_en_q    <= wr_en_d;
        end
    end

    assign wr_valid_o   = wr_valid_q;
    assign wr_rnum_o    = wr_rnum_q;
    assign wr_data_o    = wr_data_q;
    assign wr_enables_o = wr_en_q;
endmodule

// File: tb/tb_reg_write_arbiter.sv
// tb_reg_write_arbiter: self-checking bench for reg_write_arbiter (NCH=2, DEPTH=4, DATA_W=32, NUM_W=4)
module tb_reg_write_arbiter;
    localparam int NCH = 2, DEPTH = 4;

    typedef struct packed {
        logic [4:0]  rnum;
        logic [31:0] data;
    } ent_t;

    typedef struct {
        int          ch;
        logic        gf;
        logic [3:0]  num;
        logic [31:0] data;
        logic        q;
        logic [4:0]  rnum;
    } vec_t;

    logic        clk = 1'b0, rst = 1'b1, flush = 1'b0;
    logic [1:0]  in_valid = '0, in_ready, in_gf = '0;
    logic [7:0]  in_num = '0;
    logic [63:0] in_data = '0;
    logic        wr_valid;
    logic [4:0]  wr_rnum;
    logic [31:0] wr_data, wr_enables, pending;

    int   total = 0, bad = 0;
    logic chk_en = 1'b0;
    ent_t exp_q [NCH][$];
    int   iss_ch [$];

    reg_write_arbiter #(.NCH(2), .DEPTH(4), .DATA_W(32), .NUM_W(4)) dut (
        .clk_i(clk), .rst_i(rst), .flush_i(flush),
        .in_valid_i(in_valid), .in_ready_o(in_ready), .in_gf_i(in_gf),
        .in_num_i(in_num), .in_data_i(in_data),
        .wr_valid_o(wr_valid), .wr_rnum_o(wr_rnum), .wr_data_o(wr_data),
        .wr_enables_o(wr_enables), .pending_o(pending)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input int c, input logic gf, input logic [3:0] num, input logic [31:0] data);
        in_valid[c]        = 1'b1;
        in_gf[c]           = gf;
        in_num[c*4 +: 4]   = num;
        in_data[c*32 +: 32] = data;
    endtask

    // Scoreboard push on every completed handshake of a non-zero register.
    always @(posedge clk) begin
        if (rst || flush) begin
            for (int c = 0; c < NCH; c++) exp_q[c].delete();
        end else if (chk_en) begin
            for (int c = 0; c < NCH; c++)
                if (in_valid[c] && in_ready[c] && {in_gf[c], in_num[c*4 +: 4]} != 5'd0)
                    exp_q[c].push_back('{rnum: {in_gf[c], in_num[c*4 +: 4]}, data: in_data[c*32 +: 32]});
        end
    end

    // Every issue must match some channel's oldest entry; queue contents model occupancy and pending.
    always @(negedge clk) begin
        if (chk_en && !rst) begin
            int hit;
            ent_t e;
            logic [31:0] m;
            if (wr_valid) begin
                hit = -1;
                for (int c = 0; c < NCH; c++)
                    if (hit < 0 && exp_q[c].size() > 0 && exp_q[c][0] == {wr_rnum, wr_data}) hit = c;
                total++;
                if (hit < 0) begin
                    bad++;
                    $display("FAIL issue: got rnum=%0d data=%0h expected a queued head", wr_rnum, wr_data);
                end else begin
                    e = exp_q[hit].pop_front();
                    iss_ch.push_back(hit);
                    chk("enables", 64'(wr_enables), 64'(32'd1 << e.rnum));
                end
            end else chk("idle_enables", 64'(wr_enables), 64'd0);
            m = '0;
            for (int c = 0; c < NCH; c++)
                for (int k = 0; k < exp_q[c].size(); k++) m[exp_q[c][k].rnum] = 1'b1;
            chk("pending", 64'(pending), 64'(m));
            for (int c = 0; c < NCH; c++)
                chk("in_ready", 64'(in_ready[c]), 64'(!flush && exp_q[c].size() != DEPTH));
        end
    end

    initial begin
        vec_t vecs [7];
        int   rr_exp [6];
        int   idx [2];
        logic acc [2];
        logic bp_seen;
        int   cyc;
        vecs[0] = '{0, 1'b1, 4'd3,  32'hDEADBEEF, 1'b1, 5'd19};
        vecs[1] = '{1, 1'b0, 4'd0,  32'h12345678, 1'b0, 5'd0};
        vecs[2] = '{1, 1'b0, 4'd1,  32'h00000001, 1'b1, 5'd1};
        vecs[3] = '{0, 1'b1, 4'd15, 32'hFFFFFFFF, 1'b1, 5'd31};
        vecs[4] = '{1, 1'b1, 4'd0,  32'hA5A5A5A5, 1'b1, 5'd16};
        vecs[5] = '{0, 1'b0, 4'd0,  32'hCAFEF00D, 1'b0, 5'd0};
        vecs[6] = '{0, 1'b0, 4'd10, 32'h00000000, 1'b1, 5'd10};
        rr_exp  = '{0, 1, 0, 1, 0, 1};

        // Reset held two cycles with requests present
        in_valid = 2'b11;
        in_gf    = 2'b11;
        in_num   = 8'h21;
        repeat (2) tick;
        @(negedge clk);
        chk("rst_wr_valid", 64'(wr_valid), 64'd0);
        chk("rst_wr_enables", 64'(wr_enables), 64'd0);
        chk("rst_pending", 64'(pending), 64'd0);
        chk("rst_wr_rnum", 64'(wr_rnum), 64'd0);
        chk("rst_wr_data", 64'(wr_data), 64'd0);
        chk_en = 1'b1;
        tick;
        rst = 1'b0;
        in_valid = '0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("post_rst_idle", 64'(wr_valid), 64'd0);
            tick;
        end

        // Single writes: pending visible at t+1, issue at t+2
        foreach (vecs[i]) begin
            drv(vecs[i].ch, vecs[i].gf, vecs[i].num, vecs[i].data);
            @(negedge clk);
            chk("vec_ready", 64'(in_ready[vecs[i].ch]), 64'd1);
            tick;
            in_valid = '0;
            @(negedge clk);
            chk("vec_pending_t1", 64'(pending[vecs[i].rnum]), 64'(vecs[i].q));
            tick;
            @(negedge clk);
            chk("vec_wr_valid", 64'(wr_valid), 64'(vecs[i].q));
            chk("vec_wr_enables", 64'(wr_enables), vecs[i].q ? 64'(32'd1 << vecs[i].rnum) : 64'd0);
            if (vecs[i].q) begin
                chk("vec_wr_rnum", 64'(wr_rnum), 64'(vecs[i].rnum));
                chk("vec_wr_data", 64'(wr_data), 64'(vecs[i].data));
                chk("vec_pending_t2", 64'(pending[vecs[i].rnum]), 64'd0);
            end
            tick;
            tick;
        end

        // Round robin from a fresh pointer: both channels push three writes
        rst = 1'b1;
        tick;
        rst = 1'b0;
        iss_ch.delete();
        for (int k = 0; k < 3; k++) begin
            drv(0, 1'b0, 4'(k + 1), 32'h100 + k);
            drv(1, 1'b1, 4'(k + 1), 32'h200 + k);
            tick;
        end
        in_valid = '0;
        cyc = 0;
        while (iss_ch.size() < 6 && cyc < 30) begin
            tick;
            cyc++;
        end
        chk("rr_count", 64'(iss_ch.size()), 64'd6);
        for (int k = 0; k < 6 && k < iss_ch.size(); k++) chk("rr_order", 64'(iss_ch[k]), 64'(rr_exp[k]));

        // Back-to-back streams on both channels until ch0 sees backpressure
        idx = '{0, 0};
        bp_seen = 1'b0;
        cyc = 0;
        while ((idx[0] < 10 || idx[1] < 10) && cyc < 300) begin
            for (int c = 0; c < 2; c++) begin
                in_valid[c] = 1'b0;
                if (idx[c] < 10) drv(c, 1'(c), 4'(idx[c] + 1), 32'h1000 + (c << 8) + idx[c]);
            end
            @(negedge clk);
            for (int c = 0; c < 2; c++) acc[c] = in_valid[c] & in_ready[c];
            if (in_valid[0] && !in_ready[0]) bp_seen = 1'b1;
            tick;
            for (int c = 0; c < 2; c++) if (acc[c]) idx[c]++;
            cyc++;
        end
        in_valid = '0;
        chk("stream_sent", 64'(idx[0] + idx[1]), 64'd20);
        chk("stream_backpressure", 64'(bp_seen), 64'd1);
        cyc = 0;
        while ((exp_q[0].size() != 0 || exp_q[1].size() != 0) && cyc < 60) begin
            tick;
            cyc++;
        end
        chk("stream_drained", 64'(exp_q[0].size() + exp_q[1].size()), 64'd0);
        tick;
        tick;

        // Flush with queued writes to r=5 and a request presented during the flush
        drv(0, 1'b0, 4'd5, 32'h500);
        drv(1, 1'b0, 4'd5, 32'h501);
        tick;
        flush = 1'b1;
        in_valid = 2'b00;
        drv(0, 1'b0, 4'd5, 32'h502);
        @(negedge clk);
        chk("flush_ready", 64'(in_ready), 64'd0);
        chk("flush_pending_before", 64'(pending[5]), 64'd1);
        tick;
        flush = 1'b0;
        in_valid = '0;
        @(negedge clk);
        chk("flush_pending_after", 64'(pending), 64'd0);
        chk("flush_wr_valid", 64'(wr_valid), 64'd0);
        chk("flush_wr_enables", 64'(wr_enables), 64'd0);
        for (int k = 0; k < 5; k++) begin
            tick;
            @(negedge clk);
            chk("flush_no_issue", 64'(wr_valid), 64'd0);
        end
        tick;
        drv(0, 1'b0, 4'd5, 32'h503);
        tick;
        in_valid = '0;
        tick;
        @(negedge clk);
        chk("post_flush_valid", 64'(wr_valid), 64'd1);
        chk("post_flush_rnum", 64'(wr_rnum), 64'd5);
        chk("post_flush_data", 64'(wr_data), 64'h503);
        tick;
        tick;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
